// File: rtl/osc_stdby_ctrl.sv
// Oscillator standby controller.
// It sequences the oscillator through four states: a settle period after start,
// active use, a drain period before stopping, and standby.
// All outputs are registered. A condition sampled at a clock edge shows on the
// outputs right after that edge.
module osc_stdby_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned IDLE_CYCLES   = 1024,
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SLEEP_EN,
  input  logic       WAKE_REQ,
  input  logic       ACTIVITY,
  output logic       STDBY,
  output logic       OSC_READY,
  output logic [1:0] STATE,
  output logic [7:0] SLEEP_COUNT
);

  typedef enum logic [1:0] {
    StWaking  = 2'b00,
    StActive  = 2'b01,
    StDrain   = 2'b10,
    StStandby = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IdleLast   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DrainLast  = CNT_W'(DRAIN_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stdby_q;
  logic             ready_q;
  logic [7:0]       sleep_cnt_q;
  logic             wake;

  // Any reason to keep the oscillator running
  always_comb begin
    wake = WAKE_REQ | ACTIVITY | ~SLEEP_EN;
  end

  // State, shared counter and registered outputs; reset overrides every transition
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StWaking;
      cnt_q       <= '0;
      stdby_q     <= 1'b0;
      ready_q     <= 1'b0;
      sleep_cnt_q <= '0;
    end else begin
      unique case (state_q)
        // Inputs are ignored until the oscillator has settled
        StWaking: begin
          if (cnt_q == SettleLast) begin
            state_q <= StActive;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StActive: begin
          if (wake) begin
            cnt_q <= '0;
          end else if (cnt_q == IdleLast) begin
            state_q <= StDrain;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // The oscillator is still running, so a wake here skips the settle period
        StDrain: begin
          if (wake) begin
            state_q <= StActive;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else if (cnt_q == DrainLast) begin
            state_q <= StStandby;
            cnt_q   <= '0;
            stdby_q <= 1'b1;
            if (sleep_cnt_q != 8'hFF) begin
              sleep_cnt_q <= sleep_cnt_q + 8'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStandby: begin
          cnt_q <= '0;
          if (wake) begin
            state_q <= StWaking;
            stdby_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StWaking;
          cnt_q   <= '0;
          stdby_q <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign STDBY       = stdby_q;
  assign OSC_READY   = ready_q;
  assign STATE       = state_q;
  assign SLEEP_COUNT = sleep_cnt_q;

endmodule

// File: tb/tb_osc_stdby_ctrl.sv
// Bench for osc_stdby_ctrl.
// Directed steps and random steps are checked against a countdown model.
module tb_osc_stdby_ctrl;

  localparam int unsigned Settle = 4;
  localparam int unsigned Idle   = 8;
  localparam int unsigned Drain  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SLEEP_EN = 1'b0;
  logic       WAKE_REQ = 1'b0;
  logic       ACTIVITY = 1'b0;
  logic       STDBY;
  logic       OSC_READY;
  logic [1:0] STATE;
  logic [7:0] SLEEP_COUNT;

  int errors = 0;
  int checks = 0;

  // Reference model.
  // Mode follows the STATE encoding. Each phase keeps its own remaining-cycle
  // count or idle-run length.
  int m_mode   = 0;
  int m_left   = Settle;
  int m_idle   = 0;
  int m_sleeps = 0;

  osc_stdby_ctrl #(
    .SETTLE_CYCLES(Settle),
    .IDLE_CYCLES  (Idle),
    .DRAIN_CYCLES (Drain),
    .CNT_W        (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SLEEP_EN   (SLEEP_EN),
    .WAKE_REQ   (WAKE_REQ),
    .ACTIVITY   (ACTIVITY),
    .STDBY      (STDBY),
    .OSC_READY  (OSC_READY),
    .STATE      (STATE),
    .SLEEP_COUNT(SLEEP_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic model_edge(input logic rst, input logic wake);
    if (rst) begin
      m_mode = 0; m_left = Settle; m_idle = 0; m_sleeps = 0;
    end else begin
      case (m_mode)
        0: begin
          m_left--;
          if (m_left == 0) begin m_mode = 1; m_idle = 0; end
        end
        1: begin
          m_idle = wake ? 0 : m_idle + 1;
          if (m_idle == Idle) begin m_mode = 2; m_left = Drain; end
        end
        2: begin
          if (wake) begin
            m_mode = 1; m_idle = 0;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_mode = 3;
              m_sleeps = (m_sleeps < 255) ? m_sleeps + 1 : 255;
            end
          end
        end
        default: if (wake) begin m_mode = 0; m_left = Settle; end
      endcase
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs
  task automatic step(input logic rst, input logic sl, input logic wr, input logic act);
    RST = rst; SLEEP_EN = sl; WAKE_REQ = wr; ACTIVITY = act;
    @(posedge CLK);
    model_edge(rst, wr | act | ~sl);
    #1;
    check("state", int'(STATE), m_mode);
    check("stdby", int'(STDBY), int'(m_mode == 3));
    check("osc_ready", int'(OSC_READY), int'(m_mode == 1));
    check("sleep_count", int'(SLEEP_COUNT), m_sleeps);
    check("ready_stdby_exclusive", int'(STDBY & OSC_READY), 0);
  endtask

  initial begin
    // Reset, then release with sleep disabled
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_state", int'(STATE), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("still_waking", int'(STATE), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("first_active", int'(STATE), 1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("stays_active", int'(STATE), 1);

    // Idle with sleep enabled leads to drain, then standby
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("idle7_active", int'(STATE), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("enter_drain", int'(STATE), 2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("enter_standby", int'(STATE), 3);
    check("standby_stdby", int'(STDBY), 1);
    check("first_sleep", int'(SLEEP_COUNT), 1);

    // Activity wakes from standby; full settle follows
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("wake_stdby_low", int'(STDBY), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("resettled_ready", int'(OSC_READY), 1);

    // Wake request on the first drain cycle returns straight to active
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("drain_again", int'(STATE), 2);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("drain_abort", int'(STATE), 1);
    check("drain_abort_count", int'(SLEEP_COUNT), 1);

    // Activity on idle cycle 7 restarts the full idle window
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("no_early_drain", int'(STATE), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("late_drain", int'(STATE), 2);

    // Random stimulus with rare wake sources
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 11) == 0));
    end

    // Many sleep/wake rounds to saturate the counter
    for (int r = 0; r < 300; r++) begin
      for (int k = 0; k < 40 && m_mode != 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
    end
    for (int k = 0; k < 40 && m_mode != 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("saturated", int'(SLEEP_COUNT), 255);
    check("in_standby", int'(STATE), 3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_stdby", int'(STDBY), 0);
    check("rst_state", int'(STATE), 0);
    check("rst_count", int'(SLEEP_COUNT), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("post_rst_active", int'(STATE), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
